// File: rtl/mul_repadd_param_if.sv
// Operand/handshake bundle between a requester and the repeated-addition multiplier.
// The requester drives start, signed_mode and data_in; the multiplier returns busy, done and product.
interface mul_repadd_param_if #(
  parameter int WIDTH = 16
);
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   data_in;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, signed_mode, data_in,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, data_in,
    output busy, done, product
  );
endinterface

// File: rtl/mul_repadd_param.sv
// Sequential multiplier: loads A then B over one bus, adds the larger magnitude once per
// count of the smaller, then applies the sign. Full 2*WIDTH-bit product, unsigned or signed.
module mul_repadd_param #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  mul_repadd_param_if.slave  bus
);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, PREP, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, n_q, n_d;
  logic [PW-1:0]    m_q, m_d, p_q, p_d, product_q, product_d;
  logic             sm_q, sm_d, neg_q, neg_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] mag_a, mag_b;

  // Negating the most negative value wraps to itself, which read unsigned is 2^(WIDTH-1).
  assign mag_a = (sm_q && a_q[WIDTH-1]) ? -a_q : a_q;
  assign mag_b = (sm_q && b_q[WIDTH-1]) ? -b_q : b_q;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    n_d       = n_q;
    m_d       = m_q;
    p_d       = p_q;
    product_d = product_q;
    sm_d      = sm_q;
    neg_d     = neg_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sm_d    = bus.signed_mode;
          state_d = LOAD_A;
        end
      end
      LOAD_A: begin
        a_d     = bus.data_in;
        state_d = LOAD_B;
      end
      LOAD_B: begin
        b_d     = bus.data_in;
        state_d = PREP;
      end
      PREP: begin
        // Count down the smaller magnitude to keep the ADD phase short.
        if (mag_a >= mag_b) begin
          m_d = {{WIDTH{1'b0}}, mag_a};
          n_d = mag_b;
        end else begin
          m_d = {{WIDTH{1'b0}}, mag_b};
          n_d = mag_a;
        end
        neg_d     = sm_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        p_d       = '0;
        product_d = '0;
        state_d   = ADD;
      end
      ADD: begin
        if (n_q == '0) begin
          product_d = neg_q ? -p_q : p_q;
          state_d   = DONE;
        end else begin
          p_d = p_q + m_q;
          n_d = n_q - WIDTH'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d == LOAD_A) || (state_d == LOAD_B) ||
                  (state_d == PREP)   || (state_d == ADD);
  assign done_d = (state_d == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      n_q       <= '0;
      m_q       <= '0;
      p_q       <= '0;
      product_q <= '0;
      sm_q      <= 1'b0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      n_q       <= n_d;
      m_q       <= m_d;
      p_q       <= p_d;
      product_q <= product_d;
      sm_q      <= sm_d;
      neg_q     <= neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule

// File: tb/tb_mul_repadd_param.sv
// Directed bench for mul_repadd_param at WIDTH=16 and WIDTH=8: products, latency,
// busy/done handshake, ignored start pulses and synchronous reset mid-operation.
module tb_mul_repadd_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   sel8 = 1'b0;

  mul_repadd_param_if #(.WIDTH(16)) bus16 ();
  mul_repadd_param_if #(.WIDTH(8))  bus8 ();

  mul_repadd_param #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  mul_repadd_param #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  always #5 clk = ~clk;

  logic        cur_busy, cur_done;
  logic [31:0] cur_prod;
  assign cur_busy = sel8 ? bus8.busy : bus16.busy;
  assign cur_done = sel8 ? bus8.done : bus16.done;
  assign cur_prod = sel8 ? {16'h0000, bus8.product} : bus16.product;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input bit v);
    if (sel8) bus8.start = v;
    else      bus16.start = v;
  endtask

  task automatic set_sm(input bit v);
    bus8.signed_mode  = v;
    bus16.signed_mode = v;
  endtask

  task automatic drive(input logic [15:0] v);
    bus16.data_in = v;
    bus8.data_in  = v[7:0];
  endtask

  // k counts the interval E(k-1)->E(k), E0 being the edge that samples start.
  task automatic op(input bit w8, input bit sm, input logic [15:0] a, input logic [15:0] b,
                    input logic [31:0] exp_p, input int exp_lat, input bit noise, input string tag);
    int k = 0;
    int busy_err = 0;
    int spurious = 0;
    bit seen = 1'b0;
    sel8 = w8;
    @(negedge clk);
    set_start(1'b1); set_sm(sm); drive(16'($urandom));
    @(negedge clk); k = 1;
    if (!cur_busy || cur_done) busy_err++;
    set_start(1'b0); set_sm(~sm); drive(a);
    @(negedge clk); k = 2;
    if (!cur_busy || cur_done) busy_err++;
    drive(b); set_start(noise);
    while (k < 600 && !seen) begin
      @(negedge clk); k++;
      if (cur_done) begin
        seen = 1'b1;
        if (cur_busy) busy_err++;
      end else if (!cur_busy) busy_err++;
      drive(16'($urandom)); set_sm($urandom_range(0, 1) == 1);
      set_start(noise && (seen || k == 5));
    end
    check({tag, ".done_seen"}, 64'(seen), 64'd1);
    check({tag, ".latency"}, 64'(k - 1), 64'(exp_lat));
    check({tag, ".product"}, 64'(cur_prod), 64'(exp_p));
    check({tag, ".busy_window"}, 64'(busy_err), 64'd0);
    @(negedge clk);
    set_start(1'b0);
    check({tag, ".idle_after"}, {62'd0, cur_busy, cur_done}, 64'd0);
    check({tag, ".held"}, 64'(cur_prod), 64'(exp_p));
    if (noise) begin
      repeat (6) begin
        @(negedge clk);
        if (cur_done || cur_busy || cur_prod !== exp_p) spurious++;
      end
      check({tag, ".ignored_start"}, 64'(spurious), 64'd0);
    end
  endtask

  initial begin
    int k;
    int dones;
    bus16.start = 1'b0; bus8.start = 1'b0;
    set_sm(1'b0); drive(16'h0000);

    // Start held high while in reset must be ignored.
    @(negedge clk);
    bus16.start = 1'b1; bus8.start = 1'b1;
    repeat (3) @(negedge clk);
    check("rst16.outputs", {bus16.busy, bus16.done, bus16.product}, 64'd0);
    check("rst8.outputs", {bus8.busy, bus8.done, bus8.product}, 64'd0);
    bus16.start = 1'b0; bus8.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.idle", {bus16.busy, bus16.done, bus8.busy, bus8.done}, 64'd0);

    op(1'b0, 1'b0, 16'd17,   16'd5,    32'd85,        9, 1'b0, "u16_17x5");
    op(1'b0, 1'b1, 16'hFFFD, 16'd7,    32'hFFFF_FFEB, 7, 1'b0, "s16_m3x7");
    op(1'b0, 1'b0, 16'hFFFD, 16'd7,    32'd458731,   11, 1'b0, "u16_fffdx7");
    op(1'b0, 1'b0, 16'd0,    16'd1234, 32'd0,         4, 1'b0, "u16_0x1234");
    op(1'b0, 1'b1, 16'd0,    16'hFB2E, 32'd0,         4, 1'b0, "s16_0xneg");
    op(1'b0, 1'b0, 16'd5,    16'd1000, 32'd5000,      9, 1'b0, "u16_5x1000");
    op(1'b0, 1'b0, 16'd1000, 16'd5,    32'd5000,      9, 1'b0, "u16_1000x5");
    op(1'b0, 1'b1, 16'd3,    16'hFFFC, 32'hFFFF_FFF4, 7, 1'b0, "s16_3xm4");
    op(1'b0, 1'b0, 16'd6,    16'd9,    32'd54,       10, 1'b1, "u16_noise");

    op(1'b1, 1'b1, 16'h0080, 16'h0080, 32'h0000_4000, 132, 1'b0, "s8_m128sq");
    op(1'b1, 1'b1, 16'h0080, 16'h0001, 32'h0000_FF80,   5, 1'b0, "s8_m128x1");
    op(1'b1, 1'b0, 16'h00FF, 16'h00FF, 32'd65025,     259, 1'b0, "u8_255sq");
    op(1'b1, 1'b1, 16'h00FF, 16'h00FF, 32'd1,           5, 1'b0, "s8_m1sq");

    // Reset asserted at E6 while 17 x 5 is in ADD.
    sel8 = 1'b0;
    @(negedge clk);
    set_start(1'b1); set_sm(1'b0);
    @(negedge clk); k = 1; set_start(1'b0); drive(16'd17);
    @(negedge clk); k = 2; drive(16'd5);
    while (k < 6) begin
      @(negedge clk); k++;
    end
    check("rstmid.busy_before", 64'(cur_busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstmid.outputs", {cur_busy, cur_done, cur_prod}, 64'd0);
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (cur_done || cur_busy) dones++;
    end
    check("rstmid.no_done", 64'(dones), 64'd0);
    op(1'b0, 1'b0, 16'd3, 16'd4, 32'd12, 7, 1'b0, "rst_3x4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
